// File: rtl/cache_ctrl.sv
// Cache controller: tag/valid/dirty flops, hit path, dirty-victim
// writeback and 8-beat refill for a 4-way, 16-set, 64 B-line cache.
// Ports:
//   clk, rst              clock, async active-high reset
//   req_* / resp_*        CPU request (valid/ready) and response pulse
//   mem_rd_*              refill request + 8 incoming beats
//   mem_wr_*              writeback beats (valid/ready, last on beat 7)
//   sram_*                drives the cache_sram data array
module cache_ctrl #(
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        mem_rd_req,
   input  logic        mem_rd_ack,
   output logic [31:0] mem_rd_addr,
   input  logic        mem_rd_valid,
   input  logic [63:0] mem_rd_data,
   output logic        mem_wr_valid,
   input  logic        mem_wr_ready,
   output logic [31:0] mem_wr_addr,
   output logic [63:0] mem_wr_data,
   output logic        mem_wr_last,
   output logic [1:0]  sram_way,
   output logic [3:0]  sram_index,
   output logic [5:0]  sram_offset,
   output logic [5:0]  sram_offset_r,
   output logic        sram_r_en,
   output logic        sram_w_en,
   output logic [63:0] sram_w_data,
   output logic [7:0]  sram_w_strb,
   input  logic [63:0] sram_r_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_RESP,
      S_WB_RD,
      S_WB_CAP,
      S_WB_SEND,
      S_RF_REQ,
      S_RF
   } state_t;

   state_t state_q, state_d;

   // Byte-within-beat bits are never needed
   logic [31:3] addr_q, addr_d;
   logic        wen_q, wen_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wstrb_q, wstrb_d;

   logic [3:0][15:0][21:0] tag_q, tag_d;
   logic [3:0][15:0]       valid_q, valid_d;
   logic [3:0][15:0]       dirty_q, dirty_d;

   logic [1:0]  way_q, way_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [63:0] wb_buf_q, wb_buf_d;
   logic        last_q, last_d;
   logic [5:0]  offset_r_q, offset_r_d;

   logic [3:0]  idx;
   logic [21:0] req_tag;
   logic        hit;
   logic [1:0]  hit_way;
   logic [1:0]  vic_way;
   logic        unused_lsb;

   assign unused_lsb = ^req_addr[2:0];

   assign idx     = addr_q[9:6];
   assign req_tag = addr_q[31:10];

   assign mem_wr_last   = last_q;
   assign sram_offset_r = offset_r_q;

   // Tags are unique within a set, so at most one way matches
   always_comb begin
      hit     = 1'b0;
      hit_way = 2'd0;
      for (int w = 0; w < 4; w++) begin
         if (valid_q[w[1:0]][idx] &&
             tag_q[w[1:0]][idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = w[1:0];
         end
      end
   end

   // Lowest invalid way wins; a full set falls back to the LFSR
   always_comb begin
      vic_way = lfsr_q[1:0];
      for (int w = 3; w >= 0; w--) begin
         if (!valid_q[w[1:0]][idx]) begin
            vic_way = w[1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      tag_d    = tag_q;
      valid_d  = valid_q;
      dirty_d  = dirty_q;
      way_d    = way_q;
      cnt_d    = cnt_q;
      wb_buf_d = wb_buf_q;
      last_d   = last_q;
      lfsr_d   = {lfsr_q[6:0],
                  lfsr_q[7] ^ lfsr_q[5] ^
                  lfsr_q[4] ^ lfsr_q[3]};

      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_rdata   = 64'd0;
      mem_rd_req   = 1'b0;
      mem_rd_addr  = 32'd0;
      mem_wr_valid = 1'b0;
      mem_wr_addr  = 32'd0;
      mem_wr_data  = 64'd0;
      sram_way     = 2'd0;
      sram_index   = 4'd0;
      sram_offset  = 6'd0;
      sram_r_en    = 1'b0;
      sram_w_en    = 1'b0;
      sram_w_data  = 64'd0;
      sram_w_strb  = 8'd0;

      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr[31:3];
               wen_d   = req_wen;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               state_d = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            sram_index  = idx;
            sram_offset = {addr_q[5:3], 3'b000};
            if (hit) begin
               sram_way = hit_way;
               if (wen_q) begin
                  sram_w_en   = 1'b1;
                  sram_w_data = wdata_q;
                  sram_w_strb = wstrb_q;
                  dirty_d[hit_way][idx] = 1'b1;
               end else begin
                  sram_r_en = 1'b1;
               end
               state_d = S_RESP;
            end else begin
               way_d = vic_way;
               cnt_d = 3'd0;
               if (valid_q[vic_way][idx] &&
                   dirty_q[vic_way][idx]) begin
                  state_d = S_WB_RD;
               end else begin
                  state_d = S_RF_REQ;
               end
            end
         end

         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = wen_q ? 64'd0 : sram_r_data;
            state_d    = S_IDLE;
         end

         S_WB_RD: begin
            sram_r_en   = 1'b1;
            sram_way    = way_q;
            sram_index  = idx;
            sram_offset = {cnt_q, 3'b000};
            state_d     = S_WB_CAP;
         end

         S_WB_CAP: begin
            wb_buf_d = sram_r_data;
            last_d   = (cnt_q == 3'd7);
            state_d  = S_WB_SEND;
         end

         S_WB_SEND: begin
            mem_wr_valid = 1'b1;
            // Victim tag is untouched until refill, so address holds
            mem_wr_addr  = {tag_q[way_q][idx], idx, 6'd0};
            mem_wr_data  = wb_buf_q;
            if (mem_wr_ready) begin
               last_d = 1'b0;
               if (last_q) begin
                  cnt_d   = 3'd0;
                  state_d = S_RF_REQ;
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  state_d = S_WB_RD;
               end
            end
         end

         S_RF_REQ: begin
            mem_rd_req  = 1'b1;
            mem_rd_addr = {addr_q[31:6], 6'd0};
            if (mem_rd_ack) begin
               valid_d[way_q][idx] = 1'b0;
               dirty_d[way_q][idx] = 1'b0;
               cnt_d   = 3'd0;
               state_d = S_RF;
            end
         end

         S_RF: begin
            sram_way    = way_q;
            sram_index  = idx;
            sram_offset = {cnt_q, 3'b000};
            if (mem_rd_valid) begin
               sram_w_en   = 1'b1;
               sram_w_data = mem_rd_data;
               sram_w_strb = 8'hFF;
               cnt_d       = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  tag_d[way_q][idx]   = req_tag;
                  valid_d[way_q][idx] = 1'b1;
                  dirty_d[way_q][idx] = 1'b0;
                  state_d = S_LOOKUP;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign offset_r_d = sram_offset;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= 64'd0;
         wstrb_q    <= 8'd0;
         tag_q      <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         way_q      <= 2'd0;
         cnt_q      <= 3'd0;
         lfsr_q     <= LFSR_SEED;
         wb_buf_q   <= 64'd0;
         last_q     <= 1'b0;
         offset_r_q <= 6'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wen_q      <= wen_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         tag_q      <= tag_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         way_q      <= way_d;
         cnt_q      <= cnt_d;
         lfsr_q     <= lfsr_d;
         wb_buf_q   <= wb_buf_d;
         last_q     <= last_d;
         offset_r_q <= offset_r_d;
      end
   end

endmodule
